// File: rtl/spi_sram_64k.sv
// spi_sram_64k: 23LC512-style SPI serial SRAM slave (single IO, SPI mode 0), pins oversampled by HCLK.
// Optional macro SPI_SRAM_HOLD_EN enables HOLD_N_SIO3 support; without it the hold pin is unused.
module spi_sram_64k #(
    parameter int ADDR_WIDTH = 16,
    parameter int PAGE_SIZE  = 32
) (
    input  logic HCLK,
    input  logic RESET,
    input  logic CS_N,
    input  logic SCK,
    input  logic SI_SIO0,
    output logic SO_SIO1,
    output logic SO_OE,
    input  logic HOLD_N_SIO3
);
    localparam int PW = $clog2(PAGE_SIZE);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, RDMR, WRMR, IGNORE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [14:0]           sr_q, sr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_q, rd_d;
    logic                  so_q, so_d;
    logic                  oe_q, oe_d;
    logic                  held_q, held_d;

    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic sck_s1_q, sck_s2_q, sck_prev_q;
    logic si_s1_q, si_s2_q;

    logic        held, sck_rise, sck_fall, mem_we;
    logic [15:0] sr_next;
    logic [7:0]  rd_byte, mr_byte;
    logic [7:0]  mem [0:(1<<ADDR_WIDTH)-1];

`ifdef SPI_SRAM_HOLD_EN
    logic hold_s1_q, hold_s2_q;

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            hold_s1_q <= 1'b1;
            hold_s2_q <= 1'b1;
        end else begin
            hold_s1_q <= HOLD_N_SIO3;
            hold_s2_q <= hold_s1_q;
        end
    end

    assign held = ~hold_s2_q & ~cs_s2_q;
`else
    logic unused_hold;
    assign unused_hold = HOLD_N_SIO3;
    assign held        = 1'b0;
`endif

    // Edges are suppressed while held so every piece of state stays frozen.
    assign sck_rise = sck_s2_q & ~sck_prev_q & ~held;
    assign sck_fall = ~sck_s2_q & sck_prev_q & ~held;
    assign sr_next  = {sr_q, si_s2_q};
    assign rd_byte  = mem[addr_q];
    assign mr_byte  = {mode_q, 6'b000000};

    assign SO_SIO1 = so_q & ~held_q;
    assign SO_OE   = oe_q & ~held_q;

    function automatic logic [ADDR_WIDTH-1:0] adv(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [1:0] m);
        logic [ADDR_WIDTH-1:0] r;
        r = a + ADDR_WIDTH'(1);
        if (m == 2'b10) r = {a[ADDR_WIDTH-1:PW], a[PW-1:0] + PW'(1)};
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        so_d    = so_q;
        oe_d    = oe_q;
        held_d  = held;
        // A byte finishing in the same cycle as CS_N rising is still committed.
        mem_we  = (state_q == WDATA) && sck_rise && (cnt_q == 4'd7);

        if (cs_s2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            so_d    = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cs_prev_q) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
                CMD: if (sck_rise) begin
                    sr_d  = sr_next[14:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        case (sr_next[7:0])
                            8'h03:   begin state_d = ADDR; rd_d = 1'b1; end
                            8'h02:   begin state_d = ADDR; rd_d = 1'b0; end
                            8'h05:   state_d = RDMR;
                            8'h01:   state_d = WRMR;
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (sck_rise) begin
                    sr_d  = sr_next[14:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        addr_d  = sr_next[ADDR_WIDTH-1:0];
                        state_d = rd_q ? RDATA : WDATA;
                    end
                end
                RDATA: if (sck_fall) begin
                    so_d  = rd_byte[~cnt_q[2:0]];
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        // Byte mode: bit 0 stays on the pin until the next fall, which drops OE.
                        if (mode_q == 2'b00) state_d = IGNORE;
                        else                 addr_d  = adv(addr_q, mode_q);
                    end
                end
                WDATA: if (sck_rise) begin
                    sr_d  = sr_next[14:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (mode_q == 2'b00) state_d = IGNORE;
                        else                 addr_d  = adv(addr_q, mode_q);
                    end
                end
                RDMR: if (sck_fall) begin
                    so_d  = mr_byte[~cnt_q[2:0]];
                    oe_d  = 1'b1;
                    cnt_d = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
                end
                WRMR: if (sck_rise) begin
                    sr_d  = sr_next[14:0];
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        if (sr_next[7:6] != 2'b11) mode_d = sr_next[7:6];
                    end
                end
                IGNORE: if (sck_fall) begin
                    so_d = 1'b0;
                    oe_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            // CS sync resets low so a CS_N held low through reset is never seen as a fall.
            cs_s1_q    <= 1'b0;
            cs_s2_q    <= 1'b0;
            cs_prev_q  <= 1'b0;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            si_s1_q    <= 1'b0;
            si_s2_q    <= 1'b0;
            state_q    <= IDLE;
            mode_q     <= 2'b01;
            cnt_q      <= '0;
            sr_q       <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            so_q       <= 1'b0;
            oe_q       <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            cs_s1_q    <= CS_N;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sck_s1_q   <= SCK;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            si_s1_q    <= SI_SIO0;
            si_s2_q    <= si_s1_q;
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            so_q       <= so_d;
            oe_q       <= oe_d;
            held_q     <= held_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_we) mem[addr_q] <= sr_next[7:0];
    end
endmodule

// File: tb/tb_spi_sram_64k.sv
// Directed bench for spi_sram_64k: SPI mode 0 master with SCK = HCLK/8, hand-computed expectations.
// Hold checks are compiled in when SPI_SRAM_HOLD_EN is defined.
module tb_spi_sram_64k;
    localparam int HALF = 40;

    logic HCLK = 1'b0;
    logic RESET, CS_N, SCK, SI_SIO0, HOLD_N_SIO3;
    logic SO_SIO1, SO_OE;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx, rx2;
    logic       oe_all, oe_any;

    spi_sram_64k dut (
        .HCLK(HCLK), .RESET(RESET), .CS_N(CS_N), .SCK(SCK), .SI_SIO0(SI_SIO0),
        .SO_SIO1(SO_SIO1), .SO_OE(SO_OE), .HOLD_N_SIO3(HOLD_N_SIO3)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift n bits MSB-first; SO is sampled just before each rising edge.
    task automatic xfer_n(input logic [7:0] tx, input int n, output logic [7:0] r,
                          output logic all, output logic any);
        logic [2:0] b;
        r = 8'h00; all = 1'b1; any = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = 3'(7 - i);
            SI_SIO0 = tx[b];
            #HALF;
            r[b] = SO_SIO1;
            all  = all & SO_OE;
            any  = any | SO_OE;
            SCK = 1'b1;
            #HALF;
            SCK = 1'b0;
        end
    endtask

    task automatic bx(input logic [7:0] tx);
        xfer_n(tx, 8, rx, oe_all, oe_any);
    endtask

    task automatic cs_lo();
        CS_N = 1'b0;
        #HALF;
    endtask

    task automatic cs_hi();
        #HALF;
        CS_N = 1'b1;
        #(4 * HALF);
    endtask

    task automatic wrmr(input logic [7:0] v);
        cs_lo(); bx(8'h01); bx(v); cs_hi();
    endtask

    task automatic rdmr_chk(input string tag, input logic [7:0] exp);
        cs_lo(); bx(8'h05); bx(8'h00); chk(tag, rx, exp); cs_hi();
    endtask

    task automatic cmd_addr(input logic [7:0] cmd, input logic [15:0] a);
        cs_lo(); bx(cmd); bx(a[15:8]); bx(a[7:0]);
    endtask

    initial begin
        RESET = 1'b1; CS_N = 1'b1; SCK = 1'b0; SI_SIO0 = 1'b0; HOLD_N_SIO3 = 1'b1;
        #52;
        RESET = 1'b0;
        #100;
        chk("reset_so", {7'd0, SO_SIO1}, 8'h00);
        chk("reset_oe", {7'd0, SO_OE}, 8'h00);

        // Mode register: default sequential, repeats on further clocks
        cs_lo(); bx(8'h05);
        bx(8'h00); chk("rdmr_default", rx, 8'h40); chk("rdmr_oe", {7'd0, oe_all}, 8'h01);
        bx(8'h00); chk("rdmr_repeat", rx, 8'h40);
        cs_hi();
        wrmr(8'h00); rdmr_chk("rdmr_byte", 8'h00);
        wrmr(8'hC0); rdmr_chk("rdmr_reserved", 8'h00);
        wrmr(8'h40); rdmr_chk("rdmr_seq", 8'h40);

        // Unknown opcode produces no response
        cs_lo(); bx(8'hFF); bx(8'h00);
        chk("ignore_oe", {7'd0, oe_any}, 8'h00); chk("ignore_so", rx, 8'h00);
        cs_hi();

        // Sequential write/read
        cmd_addr(8'h02, 16'h1234); bx(8'hA5); bx(8'h5A); bx(8'hC3); cs_hi();
        cmd_addr(8'h03, 16'h1234);
        bx(8'h00); chk("seq_rd0", rx, 8'hA5); chk("seq_rd0_oe", {7'd0, oe_all}, 8'h01);
        bx(8'h00); chk("seq_rd1", rx, 8'h5A);
        bx(8'h00); chk("seq_rd2", rx, 8'hC3);
        cs_hi();

        // Sequential wrap at top of array
        cmd_addr(8'h02, 16'hFFFF); bx(8'h11); bx(8'h22); cs_hi();
        cmd_addr(8'h03, 16'hFFFF);
        bx(8'h00); chk("wrap_rd0", rx, 8'h11);
        bx(8'h00); chk("wrap_rd1", rx, 8'h22);
        cs_hi();
        cmd_addr(8'h03, 16'h0000); bx(8'h00); chk("wrap_at0", rx, 8'h22); cs_hi();

        // Page mode wrap within a 32-byte page
        wrmr(8'h80);
        cmd_addr(8'h02, 16'h003F); bx(8'h01); bx(8'h02); bx(8'h03); cs_hi();
        cmd_addr(8'h03, 16'h003F);
        bx(8'h00); chk("page_rd0", rx, 8'h01);
        bx(8'h00); chk("page_rd1", rx, 8'h02);
        bx(8'h00); chk("page_rd2", rx, 8'h03);
        cs_hi();
        wrmr(8'h40);
        cmd_addr(8'h03, 16'h0020);
        bx(8'h00); chk("page_at20", rx, 8'h02);
        bx(8'h00); chk("page_at21", rx, 8'h03);
        cs_hi();

        // Byte mode: one byte per transaction
        cmd_addr(8'h02, 16'h0501); bx(8'h33); cs_hi();
        wrmr(8'h00);
        cmd_addr(8'h03, 16'h1234);
        bx(8'h00); chk("byte_rd0", rx, 8'hA5);
        bx(8'h00); chk("byte_rd1_oe", {7'd0, oe_any}, 8'h00); chk("byte_rd1_so", rx, 8'h00);
        cs_hi();
        cmd_addr(8'h02, 16'h0500); bx(8'h99); bx(8'h88); cs_hi();
        wrmr(8'h40);
        cmd_addr(8'h03, 16'h0500);
        bx(8'h00); chk("byte_wr0", rx, 8'h99);
        bx(8'h00); chk("byte_wr1", rx, 8'h33);
        cs_hi();

        // Aborted write after 4 data bits leaves memory untouched
        cmd_addr(8'h02, 16'h0100); bx(8'h5C); cs_hi();
        cmd_addr(8'h02, 16'h0100); xfer_n(8'h77, 4, rx, oe_all, oe_any); cs_hi();
        cmd_addr(8'h03, 16'h0100); bx(8'h00); chk("abort_keep", rx, 8'h5C); cs_hi();

`ifdef SPI_SRAM_HOLD_EN
        // Hold mid-read for 10 SCK periods
        cmd_addr(8'h03, 16'h1234);
        xfer_n(8'h00, 4, rx, oe_all, oe_any);
        HOLD_N_SIO3 = 1'b0;
        #HALF;
        oe_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SI_SIO0 = i[0];
            #HALF;
            oe_any = oe_any | SO_OE;
            SCK = 1'b1; #HALF; SCK = 1'b0;
        end
        chk("hold_oe", {7'd0, oe_any}, 8'h00);
        HOLD_N_SIO3 = 1'b1;
        #HALF;
        xfer_n(8'h00, 4, rx2, oe_all, oe_any);
        chk("hold_byte", {rx[7:4], rx2[7:4]}, 8'hA5);
        bx(8'h00); chk("hold_next", rx, 8'h5A);
        cs_hi();
`endif

        // Reset mid-transaction: mode back to sequential, no restart until a new CS fall
        wrmr(8'h80);
        cs_lo(); bx(8'h05);
        RESET = 1'b1; #30; RESET = 1'b0; #20;
        bx(8'h05); bx(8'h00);
        chk("rst_mid_quiet", {7'd0, oe_any}, 8'h00);
        cs_hi();
        rdmr_chk("rst_mid_mode", 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
